// File: rtl/serial_sub4_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side; the slave (the subtractor) drives results.
interface serial_sub4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             b_in;
    logic             ack;
    logic             ready;
    logic [WIDTH-1:0] D;
    logic             b_out;
    logic             ovf;
    logic             done;

    modport master (
        output start, A, B, b_in, ack,
        input  ready, D, b_out, ovf, done
    );

    modport slave (
        input  start, A, B, b_in, ack,
        output ready, D, b_out, ovf, done
    );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: computes A - B - b_in LSB first, one bit per clock,
// using a single borrow flip-flop. Three-state handshake IDLE -> RUN -> DONE,
// result held in DONE until acknowledged and kept afterwards until the next accept.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    serial_sub4_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Difference bit of a full subtractor stage.
    function automatic logic f_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    // Borrow-out of a full subtractor stage.
    function automatic logic f_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;
    logic             r_ready;
    logic             r_done;
    logic             w_last;
    logic             w_d_bit;
    logic             w_br_nxt;

    // Current-bit arithmetic on the operand LSBs and the stored borrow.
    always_comb begin
        w_d_bit  = f_diff(r_a[0], r_b[0], r_br);
        w_br_nxt = f_borrow(r_a[0], r_b[0], r_br);
        w_last   = (r_cnt == LAST);
    end

    // Next-state logic; start is only seen in IDLE and ack only in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_RUN;
                else           w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_state_nxt = S_RUN;
            end
            S_DONE: begin
                if (bus.ack) w_state_nxt = S_IDLE;
                else         w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered ready/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Operand capture, serial shift of result bits and final flag update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_a_msb <= bus.A[WIDTH-1];
                        r_b_msb <= bus.B[WIDTH-1];
                        r_br    <= bus.b_in;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt;
                    end
                end
                S_RUN: begin
                    r_d   <= {w_d_bit, r_d[WIDTH-1:1]};
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + ONE;
                    // The bit produced on the last edge is the result MSB.
                    if (w_last) begin
                        r_bout <= w_br_nxt;
                        r_ovf  <= (r_a_msb != r_b_msb) && (w_d_bit != r_a_msb);
                    end else begin
                        r_bout <= r_bout;
                    end
                end
                S_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.D     = r_d;
    assign bus.b_out = r_bout;
    assign bus.ovf   = r_ovf;
endmodule
